// File: rtl/fetch_request_unit.sv
// Fetch request unit: issues icache reads at the registered pc, steers the PC unit
// (sequential step or redirect) and hands fetched words to decode through a one-entry slot.
module fetch_request_unit #(
    parameter int WORD_W  = 32,
    parameter int PC_STEP = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic [WORD_W-1:0] pc,
    output logic [WORD_W-1:0] pc_comb,
    output logic              pc_incr,
    output logic              imemREN,
    output logic [WORD_W-1:0] imemaddr,
    input  logic              ihit,
    input  logic [WORD_W-1:0] imemload,
    input  logic              redirect_valid,
    input  logic [WORD_W-1:0] redirect_target,
    input  logic              halt,
    input  logic              id_ready,
    output logic              instr_valid,
    output logic [WORD_W-1:0] instr,
    output logic [WORD_W-1:0] instr_pc,
    output logic [WORD_W-1:0] instr_npc
);

    localparam logic [WORD_W-1:0] STEP = WORD_W'(PC_STEP);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        HALTED
    } state_e;

    state_e            state_q, state_d;
    logic              slot_valid_q, slot_valid_d;
    logic [WORD_W-1:0] slot_instr_q, slot_instr_d;
    logic [WORD_W-1:0] slot_pc_q, slot_pc_d;
    logic [WORD_W-1:0] pend_target_q, pend_target_d;

    logic              slot_free;
    logic              load_slot;
    logic              clear_slot;

    assign slot_free = !slot_valid_q || id_ready;

    always_comb begin
        state_d       = state_q;
        pend_target_d = pend_target_q;
        pc_comb       = pc;
        pc_incr       = 1'b0;
        imemREN       = 1'b0;
        imemaddr      = pc;
        load_slot     = 1'b0;
        clear_slot    = 1'b0;

        // halt outranks redirect and ihit in every state
        if (halt) begin
            state_d    = HALTED;
            clear_slot = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = FETCH;
                    if (redirect_valid) begin
                        pc_incr    = 1'b1;
                        pc_comb    = redirect_target;
                        clear_slot = 1'b1;
                    end
                end
                FETCH: begin
                    imemREN = slot_free;
                    if (redirect_valid) begin
                        clear_slot = 1'b1;
                        // A request already in flight must keep its address until ihit.
                        if (slot_free && !ihit) begin
                            state_d       = DRAIN;
                            pend_target_d = redirect_target;
                        end else begin
                            pc_incr = 1'b1;
                            pc_comb = redirect_target;
                        end
                    end else if (ihit && slot_free) begin
                        load_slot = 1'b1;
                        pc_incr   = 1'b1;
                        pc_comb   = pc + STEP;
                    end
                end
                DRAIN: begin
                    imemREN    = 1'b1;
                    clear_slot = 1'b1;
                    if (redirect_valid) begin
                        pend_target_d = redirect_target;
                    end
                    if (ihit) begin
                        pc_incr = 1'b1;
                        pc_comb = redirect_valid ? redirect_target : pend_target_q;
                        state_d = FETCH;
                    end
                end
                HALTED: begin
                    clear_slot = 1'b1;
                end
            endcase
        end

        // No request and no pc update may leak out while reset is held.
        if (!nRST) begin
            pc_incr = 1'b0;
            imemREN = 1'b0;
        end

        slot_valid_d = slot_valid_q && !id_ready;
        slot_instr_d = slot_instr_q;
        slot_pc_d    = slot_pc_q;
        if (load_slot) begin
            slot_valid_d = 1'b1;
            slot_instr_d = imemload;
            slot_pc_d    = pc;
        end else if (clear_slot) begin
            slot_valid_d = 1'b0;
            slot_instr_d = '0;
            slot_pc_d    = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q       <= IDLE;
            slot_valid_q  <= 1'b0;
            slot_instr_q  <= '0;
            slot_pc_q     <= '0;
            pend_target_q <= '0;
        end else begin
            state_q       <= state_d;
            slot_valid_q  <= slot_valid_d;
            slot_instr_q  <= slot_instr_d;
            slot_pc_q     <= slot_pc_d;
            pend_target_q <= pend_target_d;
        end
    end

    assign instr_valid = slot_valid_q;
    assign instr       = slot_instr_q;
    assign instr_pc    = slot_pc_q;
    assign instr_npc   = slot_pc_q + STEP;

endmodule

// File: tb/tb_fetch_request_unit.sv
// Bench for fetch_request_unit: models the PC unit and icache, scoreboards decoded words
// and checks the pc/icache handshake cycle by cycle.
module tb_fetch_request_unit;

    localparam int W = 32;

    logic         CLK = 1'b0;
    logic         nRST;
    logic [W-1:0] pc;
    logic [W-1:0] pc_comb;
    logic         pc_incr;
    logic         imemREN;
    logic [W-1:0] imemaddr;
    logic         ihit;
    logic [W-1:0] imemload;
    logic         redirect_valid;
    logic [W-1:0] redirect_target;
    logic         halt;
    logic         id_ready;
    logic         instr_valid;
    logic [W-1:0] instr;
    logic [W-1:0] instr_pc;
    logic [W-1:0] instr_npc;

    int n_cmp = 0;
    int n_bad = 0;
    logic [W-1:0] exp_q[$];

    fetch_request_unit #(.WORD_W(W), .PC_STEP(4)) dut (
        .CLK             (CLK),
        .nRST            (nRST),
        .pc              (pc),
        .pc_comb         (pc_comb),
        .pc_incr         (pc_incr),
        .imemREN         (imemREN),
        .imemaddr        (imemaddr),
        .ihit            (ihit),
        .imemload        (imemload),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .halt            (halt),
        .id_ready        (id_ready),
        .instr_valid     (instr_valid),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .instr_npc       (instr_npc)
    );

    always #5 CLK = ~CLK;

    function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
        return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
    endfunction

    assign imemload = mem_word(imemaddr);

    // PC unit model: loads pc_comb when pc_incr is asserted
    always @(posedge CLK) begin
        if (!nRST) pc <= '0;
        else if (pc_incr) pc <= pc_comb;
    end

    task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every word decode consumes must be the next expected fetch
    always @(negedge CLK) begin : sb_mon
        logic [W-1:0] exp_pc;
        if (nRST === 1'b1 && instr_valid === 1'b1 && id_ready === 1'b1) begin
            exp_pc = 'x;
            if (exp_q.size() != 0) exp_pc = exp_q.pop_front();
            $display("txn: pc=%h instr=%h npc=%h", instr_pc, instr, instr_npc);
            check_eq("sb_pc", instr_pc, exp_pc);
            check_eq("sb_instr", instr, mem_word(exp_pc));
            check_eq("sb_npc", instr_npc, exp_pc + 32'd4);
        end
    end

    task automatic drive(input logic rst_n, input logic hit, input logic rdv,
                         input logic [W-1:0] tgt, input logic hlt, input logic rdy);
        nRST            = rst_n;
        ihit            = hit;
        redirect_valid  = rdv;
        redirect_target = tgt;
        halt            = hlt;
        id_ready        = rdy;
    endtask

    // One clock: drive just after the rising edge, return at the falling edge for checks.
    task automatic cycle(input logic rst_n, input logic hit, input logic rdv,
                         input logic [W-1:0] tgt, input logic hlt, input logic rdy);
        @(posedge CLK);
        #1;
        drive(rst_n, hit, rdv, tgt, hlt, rdy);
        @(negedge CLK);
    endtask

    initial begin
        // Reset held with ihit and redirect active: nothing may be requested or loaded
        drive(1'b0, 1'b1, 1'b1, 32'h300, 1'b0, 1'b1);
        @(negedge CLK);
        check_eq("rst_pc_incr", W'(pc_incr), 0);
        check_eq("rst_imemREN", W'(imemREN), 0);
        check_eq("rst_instr_valid", W'(instr_valid), 0);
        check_eq("rst_instr", instr, 0);
        check_eq("rst_instr_pc", instr_pc, 0);
        check_eq("rst_instr_npc", instr_npc, 32'h4);

        // Streaming with ihit=1 and id_ready=1
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        exp_q.push_back(32'hC);
        cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        check_eq("idle_imemREN", W'(imemREN), 0);
        check_eq("idle_pc_incr", W'(pc_incr), 0);
        check_eq("idle_instr_valid", W'(instr_valid), 0);
        cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        check_eq("f0_imemREN", W'(imemREN), 1);
        check_eq("f0_imemaddr", imemaddr, 32'h0);
        check_eq("f0_pc_incr", W'(pc_incr), 1);
        check_eq("f0_pc_comb", pc_comb, 32'h4);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
            check_eq("stream_valid", W'(instr_valid), 1);
            check_eq("stream_pc_comb", pc_comb, W'(8 + 4 * i));
        end

        // Miss at 0x10 for three cycles
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
            check_eq("miss_imemREN", W'(imemREN), 1);
            check_eq("miss_imemaddr", imemaddr, 32'h10);
            check_eq("miss_pc_incr", W'(pc_incr), 0);
            if (k > 0) check_eq("miss_instr_valid", W'(instr_valid), 0);
        end
        exp_q.push_back(32'h10);
        cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        check_eq("hit_pc_incr", W'(pc_incr), 1);
        check_eq("hit_pc_comb", pc_comb, 32'h14);
        check_eq("hit_imemaddr", imemaddr, 32'h10);

        // Redirect with ihit to 0x40, then redirect during a miss at 0x40
        cycle(1'b1, 1'b1, 1'b1, 32'h40, 1'b0, 1'b1);
        check_eq("rh40_pc_incr", W'(pc_incr), 1);
        check_eq("rh40_pc_comb", pc_comb, 32'h40);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        check_eq("rh40_flushed", W'(instr_valid), 0);
        check_eq("m40_imemaddr", imemaddr, 32'h40);
        check_eq("m40_pc_incr", W'(pc_incr), 0);
        cycle(1'b1, 1'b0, 1'b1, 32'h200, 1'b0, 1'b1);
        check_eq("rmiss_imemREN", W'(imemREN), 1);
        check_eq("rmiss_pc_incr", W'(pc_incr), 0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        check_eq("drain_imemREN", W'(imemREN), 1);
        check_eq("drain_imemaddr", imemaddr, 32'h40);
        check_eq("drain_instr_valid", W'(instr_valid), 0);
        check_eq("drain_pc_incr", W'(pc_incr), 0);
        cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        check_eq("drain_hit_pc_incr", W'(pc_incr), 1);
        check_eq("drain_hit_pc_comb", pc_comb, 32'h200);
        check_eq("drain_hit_valid", W'(instr_valid), 0);
        exp_q.push_back(32'h200);
        cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        check_eq("drain_word_dropped", W'(instr_valid), 0);
        check_eq("f200_pc_comb", pc_comb, 32'h204);

        // Decode stall with a full slot
        for (int k = 0; k < 2; k++) begin
            cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
            check_eq("stall_imemREN", W'(imemREN), 0);
            check_eq("stall_pc_incr", W'(pc_incr), 0);
            check_eq("stall_valid", W'(instr_valid), 1);
            check_eq("stall_instr_pc", instr_pc, 32'h200);
            check_eq("stall_instr", instr, mem_word(32'h200));
        end
        exp_q.push_back(32'h204);
        cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        check_eq("resume_imemREN", W'(imemREN), 1);
        check_eq("resume_pc_incr", W'(pc_incr), 1);
        check_eq("resume_pc_comb", pc_comb, 32'h208);

        // Redirect and ihit together (0x80), then a redirect to the top of the address space
        cycle(1'b1, 1'b1, 1'b1, 32'h80, 1'b0, 1'b1);
        check_eq("rh80_pc_incr", W'(pc_incr), 1);
        check_eq("rh80_pc_comb", pc_comb, 32'h80);
        cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1);
        check_eq("rh80_flushed", W'(instr_valid), 0);
        check_eq("rtop_pc_comb", pc_comb, 32'hFFFF_FFFC);
        exp_q.push_back(32'hFFFF_FFFC);
        cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        check_eq("wrap_pc_incr", W'(pc_incr), 1);
        check_eq("wrap_pc_comb", pc_comb, 32'h0);
        exp_q.push_back(32'h0);
        cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        check_eq("wrap_instr_pc", instr_pc, 32'hFFFF_FFFC);
        check_eq("wrap_instr_npc", instr_npc, 32'h0);

        // halt together with redirect and ihit
        cycle(1'b1, 1'b1, 1'b1, 32'h500, 1'b1, 1'b1);
        check_eq("halt_pc_incr", W'(pc_incr), 0);
        check_eq("halt_imemREN", W'(imemREN), 0);
        cycle(1'b1, 1'b1, 1'b1, 32'h500, 1'b0, 1'b1);
        check_eq("halted_pc_incr", W'(pc_incr), 0);
        check_eq("halted_imemREN", W'(imemREN), 0);
        check_eq("halted_valid", W'(instr_valid), 0);
        cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        check_eq("halted2_imemREN", W'(imemREN), 0);
        check_eq("halted2_pc_incr", W'(pc_incr), 0);
        cycle(1'b0, 1'b1, 1'b1, 32'h600, 1'b0, 1'b1);
        check_eq("rst2_pc_incr", W'(pc_incr), 0);
        check_eq("rst2_imemREN", W'(imemREN), 0);

        // Back through IDLE after reset
        exp_q.push_back(32'h0);
        cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        check_eq("idle2_imemREN", W'(imemREN), 0);
        check_eq("idle2_pc_incr", W'(pc_incr), 0);
        check_eq("idle2_valid", W'(instr_valid), 0);
        cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        check_eq("refetch_imemREN", W'(imemREN), 1);
        check_eq("refetch_pc_incr", W'(pc_incr), 1);
        check_eq("refetch_pc_comb", pc_comb, 32'h4);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        check_eq("refetch_valid", W'(instr_valid), 1);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        check_eq("sb_drained", W'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
